// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB) for R-type, lw, sw, addi, beq.
// Ports: clk, rst (sync, active-high); opcode (IR[31:26], sampled in DECODE); mem_ready (memory access done).
// Outputs: pc_write, pc_write_c, iord, er, ew, ir_write, regdst, regwrite, memtoreg, alusrc_a,
//   alusrc_b, aluop, PCSrc, illegal (one-cycle pulse), state (debug). All outputs are 0 while rst=1.
// Build option: define UC_JUMP_EN to decode opcode 000010 (j) into the JUMP state.
module uc_multiciclo #(
  parameter int ALUOP_W = 3,
  parameter logic [ALUOP_W-1:0] ALUOP_ADD = ALUOP_W'(0),
  parameter logic [ALUOP_W-1:0] ALUOP_SUB = ALUOP_W'(1),
  parameter logic [ALUOP_W-1:0] ALUOP_R = ALUOP_W'(2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_c,
  output logic               iord,
  output logic               er,
  output logic               ew,
  output logic               ir_write,
  output logic               regdst,
  output logic               regwrite,
  output logic               memtoreg,
  output logic               alusrc_a,
  output logic [1:0]         alusrc_b,
  output logic [ALUOP_W-1:0] aluop,
  output logic [1:0]         PCSrc,
  output logic               illegal,
  output logic [3:0]         state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
    ADDIWB = 4'd10, JUMP = 4'd11, ILLEGAL = 4'd12
  } state_t;
  state_t state_q, state_d;
  logic is_sw_q, is_j;
`ifdef UC_JUMP_EN
  assign is_j = opcode == 6'b000010;
`else
  assign is_j = 1'b0;
`endif
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: state_d = opcode == 6'b000000 ? EXEC :
                        (opcode == 6'b100011 || opcode == 6'b101011) ? MEMADR :
                        opcode == 6'b001000 ? ADDIEX :
                        opcode == 6'b000100 ? BRANCH :
                        is_j ? JUMP : ILLEGAL;
      MEMADR: state_d = is_sw_q ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  // Only lw/sw reach MEMADR, so remembering "is sw" is enough to pick the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) is_sw_q <= opcode == 6'b101011;
    end
  end
  // Outputs follow the state; rst masks them combinationally so nothing is asserted during reset.
  always_comb begin
    pc_write = 1'b0;
    pc_write_c = 1'b0;
    iord = 1'b0;
    er = 1'b0;
    ew = 1'b0;
    ir_write = 1'b0;
    regdst = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    alusrc_a = 1'b0;
    alusrc_b = 2'd0;
    aluop = ALUOP_ADD;
    PCSrc = 2'd0;
    illegal = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          er = 1'b1;
          alusrc_b = 2'd1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: alusrc_b = 2'd3;
        MEMADR: begin
          alusrc_a = 1'b1;
          alusrc_b = 2'd2;
        end
        MEMRD: begin
          er = 1'b1;
          iord = 1'b1;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          ew = 1'b1;
          iord = 1'b1;
        end
        EXEC: begin
          alusrc_a = 1'b1;
          aluop = ALUOP_R;
        end
        ALUWB: begin
          regwrite = 1'b1;
          regdst = 1'b1;
        end
        BRANCH: begin
          alusrc_a = 1'b1;
          aluop = ALUOP_SUB;
          pc_write_c = 1'b1;
          PCSrc = 2'd1;
        end
        ADDIEX: begin
          alusrc_a = 1'b1;
          alusrc_b = 2'd2;
        end
        ADDIWB: regwrite = 1'b1;
`ifdef UC_JUMP_EN
        JUMP: begin
          pc_write = 1'b1;
          PCSrc = 2'd2;
        end
`endif
        ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end
  assign state = rst ? 4'd0 : state_q;
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: table vectors, corner sequences and random traffic against an instruction-sequence model.
module tb_uc_multiciclo;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic pc_write, pc_write_c, iord, er, ew, ir_write, regdst, regwrite, memtoreg, alusrc_a, illegal;
  logic [1:0] alusrc_b, PCSrc;
  logic [2:0] aluop;
  logic [3:0] state;
  int checks = 0, failures = 0;
  int seq[$];
  int idx;
  typedef struct {
    logic [5:0]  op;
    logic [7:0]  mr;
    logic [31:0] trace;
    int          len;
  } vec_t;
  vec_t vt[10];
  logic [5:0] ops[7];

  uc_multiciclo dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_c(pc_write_c), .iord(iord), .er(er), .ew(ew),
    .ir_write(ir_write), .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop), .PCSrc(PCSrc),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] row(int s, logic m);
    logic pw = 0, pwc = 0, io = 0, e_r = 0, e_w = 0, irw = 0, rd = 0, rw = 0, m2r = 0, sa = 0, ill = 0;
    logic [1:0] sb = 0, pcs = 0;
    logic [2:0] op = 0;
    case (s)
      0: begin e_r = 1; sb = 1; pw = m; irw = m; end
      1: sb = 3;
      2: begin sa = 1; sb = 2; end
      3: begin e_r = 1; io = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin e_w = 1; io = 1; end
      6: begin sa = 1; op = 3'b010; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; op = 3'b001; pwc = 1; pcs = 1; end
      9: begin sa = 1; sb = 2; end
      10: rw = 1;
      11: begin pw = 1; pcs = 2; end
      12: ill = 1;
      default: ;
    endcase
    return {pw, pwc, io, e_r, e_w, irw, rd, rw, m2r, sa, sb, op, pcs, ill, 4'(s)};
  endfunction

  function automatic void route(logic [5:0] op);
    case (op)
      6'b000000: seq = '{0, 1, 6, 7};
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000100: seq = '{0, 1, 8};
`ifdef UC_JUMP_EN
      6'b000010: seq = '{0, 1, 11};
`endif
      default:   seq = '{0, 1, 12};
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic apply(input logic r, input logic [5:0] op, input logic m);
    @(negedge clk);
    rst = r;
    opcode = op;
    mem_ready = m;
    #1;
    chk("outs", {10'd0, pc_write, pc_write_c, iord, er, ew, ir_write, regdst, regwrite, memtoreg,
                 alusrc_a, alusrc_b, aluop, PCSrc, illegal, state},
        r ? 32'd0 : {10'd0, row(seq[idx], m)});
  endtask

  // Advance the instruction-sequence model: stalled phases (0,3,5) hold until mem_ready.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      seq = '{0, 1};
      idx = 0;
    end else if (!((seq[idx] == 0 || seq[idx] == 3 || seq[idx] == 5) && !mem_ready)) begin
      if (seq[idx] == 1) route(opcode);
      idx++;
      if (idx >= seq.size()) begin
        seq = '{0, 1};
        idx = 0;
      end
    end
  endtask

  initial begin
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010, 6'b111111};
    vt[0] = '{6'b000000, 8'hFF, 32'h7610, 4};
    vt[1] = '{6'b100011, 8'b01100111, 32'h4333210, 7};
    vt[2] = '{6'b101011, 8'hFF, 32'h5210, 4};
    vt[3] = '{6'b000100, 8'hFF, 32'h810, 3};
    vt[4] = '{6'b001000, 8'hFF, 32'hA910, 4};
    vt[5] = '{6'b111111, 8'hFF, 32'hC10, 3};
`ifdef UC_JUMP_EN
    vt[6] = '{6'b000010, 8'hFF, 32'hB10, 3};
`else
    vt[6] = '{6'b000010, 8'hFF, 32'hC10, 3};
`endif
    vt[7] = '{6'b000000, 8'b00011110, 32'h76100, 5};
    vt[8] = '{6'b101011, 8'b00010111, 32'h55210, 5};
    vt[9] = '{6'b000000, 8'b00000001, 32'h7610, 4};
    seq = '{0, 1};
    idx = 0;
    apply(1, 6'd0, 1'b1);
    tick();
    apply(1, 6'd0, 1'b1);
    chk("rst_state", 32'(state), 32'd0);
    tick();
    apply(0, 6'h3f, 1'b0);
    chk("post_rst", {26'd0, state, er, iord}, {26'd0, 4'd0, 1'b1, 1'b0});
    chk("post_rst_srcb", 32'(alusrc_b), 32'd1);
    tick();
    for (int v = 0; v < 10; v++)
      for (int c = 0; c < vt[v].len; c++) begin
        apply(0, vt[v].op, vt[v].mr[c]);
        chk("trace", 32'(state), 32'(vt[v].trace[4*c +: 4]));
        tick();
      end
    apply(0, 6'd0, 1'b0);
    chk("trace_end", 32'(state), 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      apply(0, 6'b100011, 1'b1);
      tick();
    end
    apply(0, 6'b100011, 1'b0);
    chk("in_memrd", 32'(state), 32'd3);
    tick();
    apply(1, 6'b100011, 1'b1);
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    tick();
    apply(0, 6'b100011, 1'b0);
    chk("rst_abandon", {30'd0, state == 4'd0, regwrite}, {30'd0, 1'b1, 1'b0});
    tick();
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 7);
      apply($urandom_range(0, 63) == 0, k == 7 ? 6'($urandom) : ops[k], $urandom_range(0, 3) != 0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
